// File: rtl/sr_display_rx_pkg.sv
// sr_display_rx_pkg: seven-segment bit order, digit patterns and frame geometry,
// shared by the serial display transmitter and receiver.
package sr_display_rx_pkg;

   localparam int DIGITS_DEF = 6;

   // Bit positions inside a segment byte {dp,g,f,e,d,c,b,a}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_0 = 8'h3F;
   localparam logic [7:0] SEG_1 = 8'h06;
   localparam logic [7:0] SEG_2 = 8'h5B;
   localparam logic [7:0] SEG_3 = 8'h4F;
   localparam logic [7:0] SEG_4 = 8'h66;
   localparam logic [7:0] SEG_5 = 8'h6D;
   localparam logic [7:0] SEG_6 = 8'h7D;
   localparam logic [7:0] SEG_7 = 8'h07;
   localparam logic [7:0] SEG_8 = 8'h7F;
   localparam logic [7:0] SEG_9 = 8'h6F;

   // Transmitter-side encoder; non-decimal nibbles blank the digit
   function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib);
      return (nib == 4'd0) ? SEG_0 :
             (nib == 4'd1) ? SEG_1 :
             (nib == 4'd2) ? SEG_2 :
             (nib == 4'd3) ? SEG_3 :
             (nib == 4'd4) ? SEG_4 :
             (nib == 4'd5) ? SEG_5 :
             (nib == 4'd6) ? SEG_6 :
             (nib == 4'd7) ? SEG_7 :
             (nib == 4'd8) ? SEG_8 :
             (nib == 4'd9) ? SEG_9 : 8'h00;
   endfunction

endpackage

// File: rtl/sr_display_rx_seg_to_bcd.sv
// seg_to_bcd: combinational seven-segment to BCD decode; the decimal point is
// ignored and any unrecognised pattern yields 0xF with o_invalid set.
module seg_to_bcd
   import sr_display_rx_pkg::*;
(
   input  logic [7:0] i_pattern,
   output logic [3:0] o_nibble,
   output logic       o_invalid
);

   always_comb begin
      o_nibble  = 4'hF;
      o_invalid = 1'b0;
      casez (i_pattern)
         {1'b?, SEG_0[SEG_G:SEG_A]}: o_nibble = 4'd0;
         {1'b?, SEG_1[SEG_G:SEG_A]}: o_nibble = 4'd1;
         {1'b?, SEG_2[SEG_G:SEG_A]}: o_nibble = 4'd2;
         {1'b?, SEG_3[SEG_G:SEG_A]}: o_nibble = 4'd3;
         {1'b?, SEG_4[SEG_G:SEG_A]}: o_nibble = 4'd4;
         {1'b?, SEG_5[SEG_G:SEG_A]}: o_nibble = 4'd5;
         {1'b?, SEG_6[SEG_G:SEG_A]}: o_nibble = 4'd6;
         {1'b?, SEG_7[SEG_G:SEG_A]}: o_nibble = 4'd7;
         {1'b?, SEG_8[SEG_G:SEG_A]}: o_nibble = 4'd8;
         {1'b?, SEG_9[SEG_G:SEG_A]}: o_nibble = 4'd9;
         default:                    o_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/sr_display_rx.sv
// sr_display_rx: receives bit-serial seven-segment bytes, decodes them into
// digit slots and publishes a BCD hh:mm:ss time once a whole frame has arrived.
module sr_display_rx
   import sr_display_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYCLES = 64,
   parameter int DIGITS      = DIGITS_DEF
)(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sclk,
   input  logic       i_sdata,
   input  logic       i_latch,
   output logic [7:0] o_seconds,
   output logic [7:0] o_minutes,
   output logic [7:0] o_hours,
   output logic       o_frame_valid,
   output logic       o_err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int TW = $clog2(IDLE_CYCLES + 1);
   localparam logic [IW-1:0] LAST_SLOT = IW'(DIGITS - 1);
   localparam logic [TW-1:0] IDLE_MAX  = TW'(IDLE_CYCLES);

   logic [SYNC_STAGES-1:0] r_sclk_s, r_sdata_s, r_latch_s;
   logic                   r_sclk_d, r_latch_d;
   logic [7:0]             r_sr;
   logic [3:0]             r_cnt;
   logic [IW-1:0]          r_idx;
   logic [TW-1:0]          r_idle;
   logic [DIGITS-1:0][3:0] r_slot;

   logic                   w_sclk, w_sdata, w_latch;
   logic                   w_sclk_rise, w_latch_rise;
   logic                   w_byte_ok, w_frame_done, w_idle_hit, w_bad;
   logic [3:0]             w_nib;
   logic [DIGITS-1:0][3:0] w_slot;

   // Decode always sees the pre-shift byte, so a coincident sclk edge cannot corrupt it
   seg_to_bcd u_dec (
      .i_pattern (r_sr),
      .o_nibble  (w_nib),
      .o_invalid (w_bad)
   );

   assign w_sclk       = r_sclk_s[SYNC_STAGES-1];
   assign w_sdata      = r_sdata_s[SYNC_STAGES-1];
   assign w_latch      = r_latch_s[SYNC_STAGES-1];
   assign w_sclk_rise  = w_sclk & ~r_sclk_d;
   assign w_latch_rise = w_latch & ~r_latch_d;
   assign w_byte_ok    = w_latch_rise && (r_cnt == 4'd8);
   assign w_frame_done = w_byte_ok && (r_idx == LAST_SLOT);
   assign w_idle_hit   = (r_idle == IDLE_MAX);

   // Slot view including the byte being stored this cycle, so the last digit reaches the outputs together with the rest
   for (genvar i = 0; i < DIGITS; i++) begin : g_slot
      assign w_slot[i] = (w_byte_ok && r_idx == IW'(i)) ? w_nib : r_slot[i];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_s      <= '0;
         r_sdata_s     <= '0;
         r_latch_s     <= '0;
         r_sclk_d      <= 1'b0;
         r_latch_d     <= 1'b0;
         r_sr          <= '0;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_idle        <= '0;
         r_slot        <= '0;
         o_seconds     <= '0;
         o_minutes     <= '0;
         o_hours       <= '0;
         o_frame_valid <= 1'b0;
         o_err         <= 1'b0;
      end else begin
         r_sclk_s  <= SYNC_STAGES'({r_sclk_s, i_sclk});
         r_sdata_s <= SYNC_STAGES'({r_sdata_s, i_sdata});
         r_latch_s <= SYNC_STAGES'({r_latch_s, i_latch});
         r_sclk_d  <= w_sclk;
         r_latch_d <= w_latch;
         if (w_sclk_rise)
            r_sr <= {r_sr[6:0], w_sdata};
         if (w_latch_rise)
            r_cnt <= {3'd0, w_sclk_rise};
         else if (w_sclk_rise)
            r_cnt <= (r_cnt == 4'd9) ? r_cnt : r_cnt + 4'd1;
         else if (w_idle_hit)
            r_cnt <= '0;
         r_idle <= (w_sclk_rise || w_latch_rise) ? '0 : w_idle_hit ? r_idle : r_idle + 1'b1;
         if (w_latch_rise)
            r_idx <= (!w_byte_ok || w_frame_done) ? '0 : r_idx + 1'b1;
         else if (w_idle_hit)
            r_idx <= '0;
         r_slot        <= w_slot;
         o_frame_valid <= w_frame_done;
         o_err         <= w_latch_rise && (r_cnt != 4'd8 || w_bad);
         if (w_frame_done) begin
            o_seconds <= {w_slot[1], w_slot[0]};
            o_minutes <= {w_slot[3], w_slot[2]};
            o_hours   <= {w_slot[5], w_slot[4]};
         end
      end
   end

endmodule

// File: tb/tb_sr_display_rx.sv
// tb_sr_display_rx: drives serial frames at the pin level and compares the DUT
// against an event-level model of bytes, slots and frames.
module tb_sr_display_rx;

   localparam int SYNC = 2;
   localparam int IDLE = 64;

   logic       clk = 1'b0;
   logic       rst_n, sclk, sdata, latch;
   logic [7:0] sec, mins, hrs;
   logic       fv, err;

   always #5 clk = ~clk;

   sr_display_rx #(.SYNC_STAGES(SYNC), .IDLE_CYCLES(IDLE), .DIGITS(6)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_sclk        (sclk),
      .i_sdata       (sdata),
      .i_latch       (latch),
      .o_seconds     (sec),
      .o_minutes     (mins),
      .o_hours       (hrs),
      .o_frame_valid (fv),
      .o_err         (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse counters and a watch for outputs changing outside a valid cycle
   int          d_valid  = 0;
   int          d_err    = 0;
   int          d_glitch = 0;
   logic [23:0] prev_out = '0;

   always @(negedge clk) begin
      if (fv) d_valid++;
      if (err) d_err++;
      if (rst_n && {hrs, mins, sec} != prev_out && !fv) d_glitch++;
      prev_out = {hrs, mins, sec};
   end

   // Reference model: a byte is whatever bits arrived since the last latch
   int         pat[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
   int         m_nbits, m_slot, m_valid, m_err;
   logic [7:0] m_sr;
   logic [3:0] m_dig[6];
   logic [7:0] m_sec, m_min, m_hr;

   function automatic int dec(input logic [7:0] b);
      for (int i = 0; i < 10; i++) begin
         logic [7:0] p;
         p = 8'(pat[i]);
         if (b[6:0] == p[6:0]) return i;
      end
      return -1;
   endfunction

   task automatic m_bit(input logic b);
      m_sr = {m_sr[6:0], b};
      if (m_nbits < 9) m_nbits++;
   endtask

   task automatic m_latch();
      int d;
      if (m_nbits != 8) begin
         m_err++;
         m_slot = 0;
      end else begin
         d = dec(m_sr);
         if (d < 0) m_err++;
         m_dig[m_slot] = (d < 0) ? 4'hF : 4'(d);
         m_slot++;
         if (m_slot == 6) begin
            m_sec = {m_dig[1], m_dig[0]};
            m_min = {m_dig[3], m_dig[2]};
            m_hr  = {m_dig[5], m_dig[4]};
            m_valid++;
            m_slot = 0;
         end
      end
      m_nbits = 0;
   endtask

   task automatic m_idle();
      m_nbits = 0;
      m_slot  = 0;
   endtask

   task automatic m_reset();
      m_nbits = 0; m_slot = 0; m_sr = '0;
      m_sec = '0; m_min = '0; m_hr = '0;
      for (int i = 0; i < 6; i++) m_dig[i] = '0;
   endtask

   // Pin-level drivers; every task starts and ends 1 time unit after a rising edge
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_bit(input logic b);
      sdata = b;
      cyc(2);
      sclk = 1'b1;
      cyc(3);
      sclk = 1'b0;
      cyc(2);
      m_bit(b);
   endtask

   task automatic tx_latch();
      bit expect_frame;
      int k;
      expect_frame = (m_nbits == 8 && m_slot == 5);
      latch = 1'b1;
      if (expect_frame) begin
         k = 0;
         do begin
            cyc(1);
            k++;
         end while (!fv && k < 20);
         check("latency", 32'(k), 32'(SYNC + 1));
      end else
         cyc(3);
      latch = 1'b0;
      cyc(3);
      m_latch();
   endtask

   task automatic tx_byte(input logic [15:0] v, input int nb);
      for (int i = nb - 1; i >= 0; i--) tx_bit(v[i]);
      tx_latch();
   endtask

   task automatic tx_frame(input int hh, input int mm, input int ss);
      int dg[6];
      dg[0] = ss % 10; dg[1] = ss / 10;
      dg[2] = mm % 10; dg[3] = mm / 10;
      dg[4] = hh % 10; dg[5] = hh / 10;
      for (int i = 0; i < 6; i++) tx_byte(16'(pat[dg[i]]), 8);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_sec"}, 32'(sec), 32'(m_sec));
      check({tag, "_min"}, 32'(mins), 32'(m_min));
      check({tag, "_hr"}, 32'(hrs), 32'(m_hr));
      check({tag, "_nvalid"}, 32'(d_valid), 32'(m_valid));
      check({tag, "_nerr"}, 32'(d_err), 32'(m_err));
   endtask

   initial begin
      logic [7:0] p0, p1;
      int r, nb;
      m_valid = 0; m_err = 0;
      m_reset();
      sclk = 1'b0; sdata = 1'b0; latch = 1'b0; rst_n = 1'b0;
      cyc(3);
      check("rst_sec", 32'(sec), 32'h0);
      check("rst_min", 32'(mins), 32'h0);
      check("rst_hr", 32'(hrs), 32'h0);
      check("rst_valid", 32'(fv), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      cyc(3);

      // Known frame 12:34:56
      tx_frame(12, 34, 56);
      check("f123456_hr", 32'(hrs), 32'h12);
      check("f123456_min", 32'(mins), 32'h34);
      check("f123456_sec", 32'(sec), 32'h56);
      check_state("f123456");

      // Short byte mid-frame discards the partial frame
      tx_byte(16'(pat[8]), 8);
      tx_byte(16'(pat[7]), 8);
      tx_byte(16'(pat[6]), 8);
      tx_byte(16'(pat[3]), 7);
      check_state("short");
      tx_frame(23, 59, 58);
      check("after_short_hr", 32'(hrs), 32'h23);
      check_state("after_short");

      // Async reset after slot 3 clears outputs without a clock edge
      for (int i = 0; i < 4; i++) tx_byte(16'(pat[i + 1]), 8);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sec", 32'(sec), 32'h0);
      check("mid_rst_min", 32'(mins), 32'h0);
      check("mid_rst_hr", 32'(hrs), 32'h0);
      m_reset();
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      tx_frame(7, 8, 9);
      check("after_rst_min", 32'(mins), 32'h08);
      check_state("after_rst");

      // Decimal point alone at slot 2 is invalid
      tx_byte(16'(pat[0]), 8);
      tx_byte(16'(pat[3]), 8);
      tx_byte(16'h80, 8);
      tx_byte(16'(pat[2]), 8);
      tx_byte(16'(pat[0]), 8);
      tx_byte(16'(pat[1]), 8);
      check("dp_only_min_lo", 32'(mins[3:0]), 32'hF);
      check_state("dp_only");

      // Idle resync between a partial frame and a full 00:00:00
      tx_byte(16'(pat[4]), 8);
      tx_byte(16'(pat[5]), 8);
      tx_byte(16'(pat[6]), 8);
      cyc(IDLE + 20);
      m_idle();
      tx_frame(0, 0, 0);
      check("idle_hms", 32'({hrs, mins, sec}), 32'h0);
      check_state("idle");

      // Coincident sclk and latch edges: latch takes the old byte, the new bit opens the next
      p0 = 8'(pat[7]);
      p1 = 8'(pat[2]);
      for (int i = 7; i >= 0; i--) tx_bit(p0[i]);
      sdata = p1[7];
      cyc(2);
      sclk = 1'b1;
      latch = 1'b1;
      cyc(3);
      sclk = 1'b0;
      latch = 1'b0;
      cyc(3);
      m_latch();
      m_bit(p1[7]);
      for (int i = 6; i >= 0; i--) tx_bit(p1[i]);
      tx_latch();
      tx_byte(16'(pat[1]), 8);
      tx_byte(16'(pat[4]), 8);
      tx_byte(16'(pat[9]), 8);
      tx_byte(16'(pat[0]), 8);
      check("simul_hms", 32'({hrs, mins, sec}), 32'h094127);
      check_state("simul");

      // Random frames with occasional malformed or unknown bytes
      for (int it = 0; it < 30; it++) begin
         cyc(IDLE + 10);
         m_idle();
         for (int s = 0; s < 6; s++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
               nb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(9, 11));
               tx_byte(16'($urandom), nb);
            end else if (r == 1)
               tx_byte(16'($urandom_range(0, 255)), 8);
            else
               tx_byte(16'(pat[$urandom_range(0, 9)]) | 16'($urandom_range(0, 1) << 7), 8);
         end
         check_state("rand");
      end

      check("glitch", 32'(d_glitch), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_display_rx.md
SR_DISPLAY_RX -- requirements
Module: sr_display_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on each serial input.
REQ-002 Parameter IDLE_CYCLES, default 64: i_clk cycles without a serial edge before frame resync.
REQ-003 Parameter DIGITS, default 6: bytes per frame.
REQ-004 Port i_clk, input, 1: single clock; all state on rising edge.
REQ-005 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port i_sclk, input, 1: serial shift clock, asynchronous to i_clk.
REQ-007 Port i_sdata, input, 1: serial data, MSB first.
REQ-008 Port i_latch, input, 1: byte-latch strobe, asynchronous to i_clk.
REQ-009 Port o_seconds, output, 8: BCD seconds {tens,units}.
REQ-010 Port o_minutes, output, 8: BCD minutes {tens,units}.
REQ-011 Port o_hours, output, 8: BCD hours {tens,units}.
REQ-012 Port o_frame_valid, output, 1: one-cycle pulse when the time outputs update.
REQ-013 Port o_err, output, 1: one-cycle pulse on a malformed byte or unknown segment pattern.

Function
REQ-014 i_sclk, i_sdata and i_latch each pass through a SYNC_STAGES flop synchroniser; rising edges are detected on the synchronised signals.
REQ-015 On each synchronised i_sclk rising edge: shift register <= {sr[6:0], sdata_sync}; bit counter increments, saturating at 9.
REQ-016 On a synchronised i_latch rising edge with bit count == 8: the 8-bit byte {dp,g,f,e,d,c,b,a} is decoded to a nibble, stored in digit slot digit_idx, digit_idx increments, and bit count clears.
REQ-017 Decode table, dp ignored: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
REQ-018 Any other pattern: nibble stored as 0xF and o_err pulses; the frame continues.
REQ-019 Slot order within a frame: 0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hour units, 5 hour tens.
REQ-020 When the slot DIGITS-1 store completes, o_seconds, o_minutes and o_hours load all slots together in the same cycle, o_frame_valid pulses for exactly 1 cycle, and digit_idx wraps to 0.
REQ-021 Latch edge with bit count != 8 (short or overlong byte): o_err pulses, the byte is discarded, the partial frame is discarded (digit_idx <= 0), bit count clears, and outputs hold.
REQ-022 Simultaneous sclk and latch edges in the same cycle: the latch uses pre-shift contents and count; the new bit then starts the next byte (bit count = 1).
REQ-023 Idle timer counts cycles without any synchronised sclk or latch edge; at IDLE_CYCLES it clears digit_idx and bit count with no o_err, then holds until the next edge.
REQ-024 Output latency: o_frame_valid asserts SYNC_STAGES+1 i_clk cycles after the final i_latch rising edge of a frame.
REQ-025 Time outputs change only on o_frame_valid cycles.

Reset
REQ-026 Asserting i_rst_n low immediately clears all synchroniser flops, shift register, bit count, digit_idx, idle timer, digit slots, o_seconds/o_minutes/o_hours (0x00), o_frame_valid (0) and o_err (0).
REQ-027 Reset mid-frame discards all partial data; the first frame after release starts at slot 0.

Structure
REQ-028 Shared package holds the ten segment-pattern constants, the segment bit-order definition and the DIGITS default, common with the display transmitter side.
REQ-029 One combinational sub-module, seg_to_bcd (8-bit pattern in; nibble and invalid flag out), performs the REQ-017/018 decode.

Verification
REQ-030 Frame 12:34:56 sent as slots 0x7D,0x6D,0x66,0x4F,0x5B,0x06 with a latch after each -> o_hours=0x12, o_minutes=0x34, o_seconds=0x56, exactly 1 o_frame_valid pulse, no o_err.
REQ-031 7 bits then latch in the middle of a frame -> o_err pulse, outputs unchanged; the next full 6-byte frame decodes correctly from slot 0.
REQ-032 Byte 0x80 (dp only) at slot 2 -> o_err pulse; after the frame, o_minutes[3:0]=0xF.
REQ-033 3 bytes, then more than IDLE_CYCLES of silence, then a full frame 00:00:00 (0x3F x6) -> outputs 0x00/0x00/0x00, no o_err.
REQ-034 i_rst_n pulsed low after slot 3 of a frame -> outputs 0x00 immediately; a following full frame decodes correctly.
REQ-035 sclk and latch edges forced into the same synchronised cycle -> the byte latches with the old 8 bits and the new bit counts as bit 1 of the next byte.
